// File: rtl/bcd_disp_pkg.sv
// rtl/bcd_disp_pkg.sv - shared types, constants and helpers for the BCD display front end
package bcd_disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    localparam int          NUM_DIGITS = 8;
    localparam int          ACC_DIGITS = 10;
    localparam logic [31:0] BCD_SAT    = 32'h9999_9999;
    localparam logic [6:0]  SEG_BLANK  = 7'h7F;

    // Number of bits needed to count 0..value-1 (0 when value is 1).
    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/seg7_enc.sv
// rtl/seg7_enc.sv - BCD digit to active-low seven-segment encoder with blanking
module seg7_enc
    import bcd_disp_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    // Segment order is {g,f,e,d,c,b,a}; a zero bit lights the segment.
    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (digit)
                4'd0:    seg = 7'b1000000;
                4'd1:    seg = 7'b1111001;
                4'd2:    seg = 7'b0100100;
                4'd3:    seg = 7'b0110000;
                4'd4:    seg = 7'b0011001;
                4'd5:    seg = 7'b0010010;
                4'd6:    seg = 7'b0000010;
                4'd7:    seg = 7'b1111000;
                4'd8:    seg = 7'b0000000;
                4'd9:    seg = 7'b0010000;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/bcd_scan_ctrl.sv
// rtl/bcd_scan_ctrl.sv - double-dabble binary-to-BCD converter and 8-digit display scanner (option: BCD_BLANK_LEADING_EN)
module bcd_scan_ctrl
    import bcd_disp_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        done,
    output logic        ovf,
    output logic [31:0] bcd,
    output logic [7:0]  an,
    output logic [6:0]  seg
);

    localparam int          PW        = (clog2(SCAN_DIV) < 1) ? 1 : clog2(SCAN_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam int          AW        = 4 * ACC_DIGITS;

    state_t          state_q, state_d;
    logic [31:0]     shreg_q, shreg_d;
    logic [AW-1:0]   acc_q, acc_d, adj;
    logic [4:0]      cnt_q, cnt_d;
    logic [31:0]     bcd_q, bcd_d;
    logic            ovf_q, ovf_d;
    logic            done_q, done_d;

    logic [PW-1:0]   presc_q;
    logic [2:0]      idx_q, idx_sel;
    logic [7:0]      an_q;
    logic [6:0]      seg_q, seg_d;
    logic            wrap;
    logic [3:0]      digit;
    logic            blank;

    assign in_ready = (state_q == ST_IDLE);
    assign done     = done_q;
    assign ovf      = ovf_q;
    assign bcd      = bcd_q;
    assign an       = an_q;
    assign seg      = seg_q;

    // Converter state and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: accept, add-3-then-shift for 32 cycles, then publish the result.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        adj     = acc_q;
        for (int i = 0; i < ACC_DIGITS; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    shreg_d = in_data;
                    acc_d   = '0;
                    cnt_d   = 5'd31;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                acc_d   = {adj[AW-2:0], shreg_q[31]};
                shreg_d = {shreg_q[30:0], 1'b0};
                if (cnt_q == 5'd0) begin
                    state_d = ST_LOAD;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            ST_LOAD: begin
                // Anything in the two top digits does not fit the 8-digit display.
                if (acc_q[AW-1:32] != '0) begin
                    ovf_d = 1'b1;
                    bcd_d = BCD_SAT;
                end else begin
                    ovf_d = 1'b0;
                    bcd_d = acc_q[31:0];
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Digit about to be shown: looks one slot ahead at a wrap so an and seg move together.
    always_comb begin
        wrap    = (presc_q == PRESC_MAX);
        idx_sel = wrap ? idx_q + 3'd1 : idx_q;
        digit   = bcd_q[{idx_sel, 2'b00} +: 4];
    end

`ifdef BCD_BLANK_LEADING_EN
    // Blank a digit when it and everything above it are zero; units and saturation always show.
    always_comb begin
        blank = (idx_sel != 3'd0) && !ovf_q && ((bcd_q >> {idx_sel, 2'b00}) == 32'd0);
    end
`else
    // All digits are always shown.
    always_comb begin
        blank = 1'b0;
    end
`endif

    seg7_enc u_seg7_enc (
        .digit (digit),
        .blank (blank),
        .seg   (seg_d)
    );

    // Free-running scan: prescaler, digit index and registered display drive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            idx_q   <= 3'd0;
            an_q    <= 8'hFE;
            seg_q   <= 7'b1000000;
        end else begin
            presc_q <= wrap ? '0 : presc_q + PW'(1);
            idx_q   <= idx_sel;
            an_q    <= ~(8'd1 << idx_sel);
            seg_q   <= seg_d;
        end
    end

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// tb/tb_bcd_scan_ctrl.sv - self-checking bench for bcd_scan_ctrl (option: BCD_BLANK_LEADING_EN)
module tb_bcd_scan_ctrl;

    localparam int DIV = 4;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        done;
    logic        ovf;
    logic [31:0] bcd;
    logic [7:0]  an;
    logic [6:0]  seg;

    int nvec = 0;
    int nerr = 0;
    int ecnt;

    logic [31:0]      mdl_bcd;
    logic             mdl_ovf;
    longint unsigned  mdl_val;

    bcd_scan_ctrl #(.SCAN_DIV(DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .done     (done),
        .ovf      (ovf),
        .bcd      (bcd),
        .an       (an),
        .seg      (seg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) ecnt <= 0;
        else     ecnt <= ecnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic longint unsigned pow10(input int n);
        longint unsigned p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    task automatic set_model(input longint unsigned v);
        mdl_val = v;
        mdl_ovf = (v > 64'd99999999);
        mdl_bcd = 32'h9999_9999;
        if (!mdl_ovf) begin
            for (int i = 0; i < 8; i++) mdl_bcd[4*i +: 4] = 4'((v / pow10(i)) % 10);
        end
    endtask

    // Handshake starts at the current negedge; in_valid stays high through busy with junk data.
    task automatic run_conv(input logic [31:0] v);
        int lat = 0;
        int busy_ready = 0;
        in_valid = 1'b1;
        in_data  = v;
        @(posedge clk); #1;
        in_data = $urandom;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                break;
            end
            if (in_ready) busy_ready++;
        end
        in_valid = 1'b0;
        set_model({32'd0, v});
        chk("latency", lat, 33);
        chk("busy_ready", busy_ready, 0);
        chk("bcd", bcd, mdl_bcd);
        chk("ovf", {31'd0, ovf}, {31'd0, mdl_ovf});
        chk("ready_after", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        chk("done_width", {31'd0, done}, 32'd0);
    endtask

    task automatic convert(input logic [31:0] v);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_wait", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        run_conv(v);
    endtask

    task automatic check_scan(input int cycles);
        int idx;
        bit blank;
        logic [7:0] exp_an;
        logic [6:0] exp_seg;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk); #1;
            idx    = (ecnt / DIV) % 8;
            exp_an = ~(8'd1 << idx);
            blank  = 1'b0;
`ifdef BCD_BLANK_LEADING_EN
            blank  = (idx != 0) && !mdl_ovf && (mdl_val < pow10(idx));
`endif
            exp_seg = blank ? 7'h7F : seg_of(int'(mdl_bcd[4*idx +: 4]));
            chk("scan_an", {24'd0, an}, {24'd0, exp_an});
            chk("scan_seg", {25'd0, seg}, {25'd0, exp_seg});
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_an"},    {24'd0, an},       32'h0000_00FE);
        chk({tag, "_seg"},   {25'd0, seg},      32'h0000_0040);
        chk({tag, "_bcd"},   bcd,               32'd0);
        chk({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
        chk({tag, "_done"},  {31'd0, done},     32'd0);
        chk({tag, "_ovf"},   {31'd0, ovf},      32'd0);
    endtask

    initial begin
        logic [31:0] v;
        int r;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        set_model(0);
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        rst = 1'b0;
        check_scan(12);

        convert(32'd12345678);
        check_scan(70);

        convert(32'd100000000);
        check_scan(8);
        convert(32'hFFFF_FFFF);
        check_scan(8);
        convert(32'd99999999);
        check_scan(8);
        convert(32'd0);
        check_scan(8);

        for (int t = 0; t < 16; t++) begin
            r = $urandom_range(0, 3);
            case (r)
                0:       v = $urandom_range(0, 999);
                1:       v = $urandom % 100000000;
                2:       v = $urandom;
                default: v = 32'd99999990 + $urandom_range(0, 20);
            endcase
            convert(v);
            check_scan(8);
        end

        convert(32'd87654321);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'd555;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            chk("abort_no_done", {31'd0, done}, 32'd0);
        end
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        set_model(0);
        @(negedge clk);
        rst = 1'b0;
        run_conv(32'd555);
        check_scan(16);

        convert(32'd42);
        check_scan(40);
        convert(32'd0);
        check_scan(40);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
